// File: rtl/lbp_histogram.sv
// 256-bin histogram of LBP codes with a valid/ready bin-by-bin readout.
// Optional feature macro: HIST_CLEAR_ON_READ_EN (clear bins on read, multi-frame operation).
module lbp_histogram #(
    parameter int CNT_W    = 14,
    parameter int NUM_BINS = 256
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             lbp_valid,
    input  logic [13:0]      lbp_addr,
    input  logic [7:0]       lbp_data,
    input  logic             finish,
    input  logic             hist_ready,
    output logic             hist_valid,
    output logic [7:0]       hist_bin,
    output logic [CNT_W-1:0] hist_count,
    output logic [13:0]      px_cnt,
    output logic             drop_err,
    output logic             done
);

    typedef enum logic [1:0] {
        ACCUM,
        DUMP,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [13:0]      PX_MAX  = '1;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] bins_q [NUM_BINS];
    logic [CNT_W-1:0] bins_d [NUM_BINS];
    logic [13:0]      px_cnt_q, px_cnt_d;
    logic             hist_valid_q, hist_valid_d;
    logic [7:0]       hist_bin_q, hist_bin_d;
    logic             drop_err_q, drop_err_d;
    logic             accept;

    // The pixel address carries no histogram information; only its arrival is counted.
    logic unused_addr;
    assign unused_addr = ^lbp_addr;

    assign accept = hist_valid_q & hist_ready;

    always_comb begin
        state_d      = state_q;
        bins_d       = bins_q;
        px_cnt_d     = px_cnt_q;
        hist_valid_d = hist_valid_q;
        hist_bin_d   = hist_bin_q;
        drop_err_d   = drop_err_q;

        case (state_q)
            ACCUM: begin
                if (lbp_valid) begin
                    if (bins_q[lbp_data] != CNT_MAX) begin
                        bins_d[lbp_data] = bins_q[lbp_data] + CNT_W'(1);
                    end
                    if (px_cnt_q != PX_MAX) begin
                        px_cnt_d = px_cnt_q + 14'd1;
                    end
                end
                if (finish) begin
                    state_d      = DUMP;
                    hist_valid_d = 1'b1;
                    hist_bin_d   = 8'd0;
                end
            end
            DUMP: begin
                if (accept) begin
                    hist_bin_d = hist_bin_q + 8'd1;
`ifdef HIST_CLEAR_ON_READ_EN
                    bins_d[hist_bin_q] = '0;
`endif
                    if (hist_bin_q == 8'hFF) begin
                        hist_valid_d = 1'b0;
                        state_d      = DONE;
                    end
                end
            end
            DONE: begin
`ifdef HIST_CLEAR_ON_READ_EN
                state_d  = ACCUM;
                px_cnt_d = 14'd0;
`else
                state_d  = DONE;
`endif
            end
            default: state_d = ACCUM;
        endcase

        // Codes arriving while the histogram is being read out are lost; flag it.
        if (lbp_valid && (state_q != ACCUM)) begin
            drop_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ACCUM;
            px_cnt_q     <= 14'd0;
            hist_valid_q <= 1'b0;
            hist_bin_q   <= 8'd0;
            drop_err_q   <= 1'b0;
            for (int i = 0; i < NUM_BINS; i++) begin
                bins_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            px_cnt_q     <= px_cnt_d;
            hist_valid_q <= hist_valid_d;
            hist_bin_q   <= hist_bin_d;
            drop_err_q   <= drop_err_d;
            bins_q       <= bins_d;
        end
    end

    // Count is read straight from the bin store so an increment in the finish cycle is visible.
    assign hist_count = hist_valid_q ? bins_q[hist_bin_q] : '0;
    assign hist_valid = hist_valid_q;
    assign hist_bin   = hist_bin_q;
    assign px_cnt     = px_cnt_q;
    assign drop_err   = drop_err_q;
    assign done       = (state_q == DONE);

endmodule

// File: tb/tb_lbp_histogram.sv
// Directed bench for lbp_histogram: a full-width instance plus a CNT_W=4 instance for saturation.
module tb_lbp_histogram;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        lbp_valid = 1'b0;
    logic [13:0] lbp_addr = 14'd0;
    logic [7:0]  lbp_data = 8'd0;
    logic        finish = 1'b0;
    logic        hist_ready = 1'b0;
    logic        hist_valid;
    logic [7:0]  hist_bin;
    logic [13:0] hist_count;
    logic [13:0] px_cnt;
    logic        drop_err;
    logic        done;

    logic        s_lbp_valid = 1'b0;
    logic [7:0]  s_lbp_data = 8'd0;
    logic        s_finish = 1'b0;
    logic        s_hist_ready = 1'b0;
    logic        s_hist_valid;
    logic [7:0]  s_hist_bin;
    logic [3:0]  s_hist_count;
    logic [13:0] s_px_cnt;
    logic        s_drop_err;
    logic        s_done;

    int checks = 0;
    int errors = 0;
    int model [256];

    lbp_histogram #(.CNT_W(14), .NUM_BINS(256)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .lbp_valid  (lbp_valid),
        .lbp_addr   (lbp_addr),
        .lbp_data   (lbp_data),
        .finish     (finish),
        .hist_ready (hist_ready),
        .hist_valid (hist_valid),
        .hist_bin   (hist_bin),
        .hist_count (hist_count),
        .px_cnt     (px_cnt),
        .drop_err   (drop_err),
        .done       (done)
    );

    lbp_histogram #(.CNT_W(4), .NUM_BINS(256)) u_sat (
        .clk        (clk),
        .reset      (reset),
        .lbp_valid  (s_lbp_valid),
        .lbp_addr   (14'd0),
        .lbp_data   (s_lbp_data),
        .finish     (s_finish),
        .hist_ready (s_hist_ready),
        .hist_valid (s_hist_valid),
        .hist_bin   (s_hist_bin),
        .hist_count (s_hist_count),
        .px_cnt     (s_px_cnt),
        .drop_err   (s_drop_err),
        .done       (s_done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drives one cycle of upstream inputs; returns at the next falling edge with them idle.
    task automatic applyStimulus(input logic v, input logic [7:0] code, input logic fin);
        lbp_valid = v;
        lbp_data  = code;
        finish    = fin;
        @(negedge clk);
        lbp_valid = 1'b0;
        finish    = 1'b0;
        lbp_addr  = lbp_addr + 14'd1;
    endtask

    task automatic sendCode(input logic [7:0] code, input logic fin);
        model[code] = model[code] + 1;
        applyStimulus(1'b1, code, fin);
    endtask

    task automatic clearModel();
        for (int i = 0; i < 256; i++) model[i] = 0;
    endtask

    // Reads all 256 bins, optionally stalling at random, checking order, counts and stability.
    task automatic dumpCheck(input bit randomReady);
        int         accepted = 0;
        int         cycles = 0;
        bit         stalled = 1'b0;
        logic [7:0] heldBin = 8'd0;
        logic [13:0] heldCnt = 14'd0;
        while (accepted < 256 && cycles < 1500) begin
            checkOutput("dump_valid", {31'd0, hist_valid}, 32'd1);
            if (hist_valid !== 1'b1) break;
            checkOutput("dump_bin", {24'd0, hist_bin}, {24'd0, accepted[7:0]});
            checkOutput("dump_count", {18'd0, hist_count}, model[accepted]);
            if (stalled) begin
                checkOutput("stall_bin", {24'd0, hist_bin}, {24'd0, heldBin});
                checkOutput("stall_count", {18'd0, hist_count}, {18'd0, heldCnt});
            end
            hist_ready = randomReady ? 1'($urandom_range(0, 1)) : 1'b1;
            stalled = !hist_ready;
            heldBin = hist_bin;
            heldCnt = hist_count;
            if (hist_ready) accepted++;
            cycles++;
            @(negedge clk);
        end
        hist_ready = 1'b0;
        checkOutput("dump_transfers", accepted, 32'd256);
        checkOutput("dump_end_valid", {31'd0, hist_valid}, 32'd0);
        checkOutput("dump_done", {31'd0, done}, 32'd1);
    endtask

    initial begin
        int guard;
        clearModel();
        repeat (2) @(negedge clk);
        checkOutput("rst_valid_held", {31'd0, hist_valid}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("rst_hist_valid", {31'd0, hist_valid}, 32'd0);
        checkOutput("rst_hist_bin", {24'd0, hist_bin}, 32'd0);
        checkOutput("rst_hist_count", {18'd0, hist_count}, 32'd0);
        checkOutput("rst_px_cnt", {18'd0, px_cnt}, 32'd0);
        checkOutput("rst_drop_err", {31'd0, drop_err}, 32'd0);
        checkOutput("rst_done", {31'd0, done}, 32'd0);

        $display("[TB] frame A: 0x5A x3, 0x00, 0xFF x10 back-to-back, 0x11 with finish");
        repeat (3) sendCode(8'h5A, 1'b0);
        sendCode(8'h00, 1'b0);
        checkOutput("px_after_4", {18'd0, px_cnt}, 32'd4);
        repeat (10) sendCode(8'hFF, 1'b0);
        sendCode(8'h11, 1'b1);
        checkOutput("px_after_finish", {18'd0, px_cnt}, 32'd15);
        checkOutput("drop_before", {31'd0, drop_err}, 32'd0);
        checkOutput("dump_entry_valid", {31'd0, hist_valid}, 32'd1);
        checkOutput("bin11_direct_model", model[8'h11], 32'd1);
        applyStimulus(1'b1, 8'h44, 1'b0);
        checkOutput("drop_err_set", {31'd0, drop_err}, 32'd1);
        checkOutput("px_after_drop", {18'd0, px_cnt}, 32'd15);
        dumpCheck(1'b1);

`ifdef HIST_CLEAR_ON_READ_EN
        @(negedge clk);
        checkOutput("done_pulse_end", {31'd0, done}, 32'd0);
        checkOutput("px_cleared", {18'd0, px_cnt}, 32'd0);
        checkOutput("accum_valid", {31'd0, hist_valid}, 32'd0);
        $display("[TB] frame 2 without reset: 0x5A, 0x22 with finish");
        clearModel();
        sendCode(8'h5A, 1'b0);
        sendCode(8'h22, 1'b1);
        checkOutput("px_frame2", {18'd0, px_cnt}, 32'd2);
        dumpCheck(1'b0);
        @(negedge clk);
        checkOutput("done_pulse2_end", {31'd0, done}, 32'd0);
`else
        repeat (5) @(negedge clk);
        checkOutput("done_holds", {31'd0, done}, 32'd1);
        checkOutput("done_valid_low", {31'd0, hist_valid}, 32'd0);
        checkOutput("px_retained", {18'd0, px_cnt}, 32'd15);
`endif

        $display("[TB] reset during readout at bin 100");
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        clearModel();
        sendCode(8'h01, 1'b0);
        sendCode(8'h02, 1'b0);
        sendCode(8'h03, 1'b1);
        hist_ready = 1'b1;
        guard = 0;
        while (hist_bin !== 8'd100 && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("reach_bin100", {24'd0, hist_bin}, 32'd100);
        reset = 1'b1;
        #1;
        checkOutput("mid_rst_valid", {31'd0, hist_valid}, 32'd0);
        checkOutput("mid_rst_count", {18'd0, hist_count}, 32'd0);
        checkOutput("mid_rst_px", {18'd0, px_cnt}, 32'd0);
        hist_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_valid", {31'd0, hist_valid}, 32'd0);
        checkOutput("post_rst_done", {31'd0, done}, 32'd0);
        clearModel();
        sendCode(8'h33, 1'b0);
        sendCode(8'h80, 1'b1);
        checkOutput("px_two_codes", {18'd0, px_cnt}, 32'd2);
        dumpCheck(1'b0);

        $display("[TB] CNT_W=4 saturation with code 0x07");
        s_lbp_data = 8'h07;
        s_lbp_valid = 1'b1;
        repeat (20) @(negedge clk);
        s_lbp_valid = 1'b0;
        checkOutput("sat_px_20", {18'd0, s_px_cnt}, 32'd20);
        s_lbp_valid = 1'b1;
        repeat (16380) @(negedge clk);
        s_lbp_valid = 1'b0;
        checkOutput("sat_px_max", {18'd0, s_px_cnt}, 32'd16383);
        s_finish = 1'b1;
        @(negedge clk);
        s_finish = 1'b0;
        s_hist_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            checkOutput("sat_valid", {31'd0, s_hist_valid}, 32'd1);
            checkOutput("sat_bin", {24'd0, s_hist_bin}, i);
            checkOutput("sat_count", {28'd0, s_hist_count}, (i == 7) ? 32'd15 : 32'd0);
            @(negedge clk);
        end
        s_hist_ready = 1'b0;
        checkOutput("sat_done", {31'd0, s_done}, 32'd1);
        checkOutput("sat_drop_err", {31'd0, s_drop_err}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
